// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control unit: sequences FETCH/DECODE/execute states and
// drives the datapath mux selects, memory strobes and ALU command.
module mc_control_fsm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       alu_zero,
    input  logic       mem_wait,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       instr_done,
    output logic       illegal
);

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_XORI = 6'h0E;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ,
        S_MEM_WB, S_MEM_WRITE, S_R_EXEC, S_R_WB, S_I_EXEC,
        S_I_WB, S_BRANCH, S_JUMP, S_JAL, S_JR
    } state_t;

    state_t r_state;
    logic   r_illegal;
    logic   w_fn_alu;

    assign w_fn_alu = (funct == FN_ADD) || (funct == FN_SUB) ||
                      (funct == FN_SLT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_illegal <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE:   r_state <= S_FETCH;
                S_FETCH:  if (!mem_wait) r_state <= S_DECODE;
                S_DECODE: begin
                    unique case (opcode)
                        OP_LW, OP_SW: r_state <= S_MEM_ADDR;
                        OP_XORI:      r_state <= S_I_EXEC;
                        OP_BNE:       r_state <= S_BRANCH;
                        OP_J:         r_state <= S_JUMP;
                        OP_JAL:       r_state <= S_JAL;
                        OP_R: begin
                            if (funct == FN_JR) begin
                                r_state <= S_JR;
                            end else if (w_fn_alu) begin
                                r_state <= S_R_EXEC;
                            end else begin
                                r_state   <= S_FETCH;
                                r_illegal <= 1'b1;
                            end
                        end
                        default: begin
                            r_state   <= S_FETCH;
                            r_illegal <= 1'b1;
                        end
                    endcase
                end
                // IR still holds the LW/SW word here
                S_MEM_ADDR:
                    r_state <= (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
                S_MEM_READ:  if (!mem_wait) r_state <= S_MEM_WB;
                S_MEM_WRITE: if (!mem_wait) r_state <= S_FETCH;
                S_R_EXEC:    r_state <= S_R_WB;
                S_I_EXEC:    r_state <= S_I_WB;
                S_MEM_WB, S_R_WB, S_I_WB,
                S_BRANCH, S_JUMP, S_JAL, S_JR:
                    r_state <= S_FETCH;
                default:     r_state <= S_IDLE;
            endcase
        end
    end

    assign illegal = r_illegal;

    always_comb begin
        pc_en      = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 2'd0;
        mem_to_reg = 2'd0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'd0;
        alu_op     = 2'd0;
        pc_src     = 2'd0;
        instr_done = 1'b0;
        unique case (r_state)
            S_FETCH: begin
                mem_read = 1'b1;
                ir_write = ~mem_wait;
                pc_en    = ~mem_wait;
            end
            S_DECODE:   alu_src_b = 2'd3;
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
            end
            S_MEM_READ: begin
                iord     = 1'b1;
                mem_read = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'd1;
                instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                iord       = 1'b1;
                mem_write  = 1'b1;
                instr_done = ~mem_wait;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd1;
                if (funct == FN_SUB)      alu_op = 2'd1;
                else if (funct == FN_SLT) alu_op = 2'd3;
                else                      alu_op = 2'd0;
            end
            S_R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 2'd1;
                instr_done = 1'b1;
            end
            S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                alu_op    = 2'd2;
            end
            S_I_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'd1;
                alu_op     = 2'd1;
                pc_src     = 2'd1;
                pc_en      = ~alu_zero;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                pc_src     = 2'd3;
                pc_en      = 1'b1;
                instr_done = 1'b1;
            end
            S_JAL: begin
                pc_src     = 2'd3;
                pc_en      = 1'b1;
                reg_write  = 1'b1;
                reg_dst    = 2'd2;
                mem_to_reg = 2'd2;
                instr_done = 1'b1;
            end
            S_JR: begin
                pc_src     = 2'd2;
                pc_en      = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: stimulus queues the expected
// per-cycle control vector, a negedge monitor pops and compares.
module tb_mc_control_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode, funct;
    logic       alu_zero, mem_wait;
    logic       pc_en, iord, mem_read, mem_write, ir_write;
    logic [1:0] reg_dst, mem_to_reg;
    logic       reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic       instr_done, illegal;

    typedef struct packed {
        logic       pc_en, iord, mem_read, mem_write, ir_write;
        logic [1:0] reg_dst, mem_to_reg;
        logic       reg_write, alu_src_a;
        logic [1:0] alu_src_b, alu_op, pc_src;
        logic       instr_done, illegal;
    } exp_t;

    exp_t  act;
    exp_t  qe[$];
    string qn[$];
    int    n_run = 0;
    int    n_fail = 0;
    logic  ill = 1'b0;

    mc_control_fsm dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
        .alu_zero(alu_zero), .mem_wait(mem_wait), .pc_en(pc_en),
        .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
        .instr_done(instr_done), .illegal(illegal)
    );

    always #5 clk = ~clk;

    assign act = '{pc_en, iord, mem_read, mem_write, ir_write, reg_dst,
                   mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
                   pc_src, instr_done, illegal};

    always @(negedge clk) begin
        if (qe.size() > 0) begin
            exp_t  e;
            string nm;
            e  = qe.pop_front();
            nm = qn.pop_front();
            n_run++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL %s: got %b want %b", nm, act, e);
            end
        end
    end

    function automatic exp_t s_zero();
        exp_t e = '0;
        return e;
    endfunction
    function automatic exp_t s_fetch(bit w);
        exp_t e = '0;
        e.mem_read = 1; e.ir_write = !w; e.pc_en = !w;
        return e;
    endfunction
    function automatic exp_t s_decode();
        exp_t e = '0;
        e.alu_src_b = 3;
        return e;
    endfunction
    function automatic exp_t s_maddr();
        exp_t e = '0;
        e.alu_src_a = 1; e.alu_src_b = 2;
        return e;
    endfunction
    function automatic exp_t s_mread();
        exp_t e = '0;
        e.iord = 1; e.mem_read = 1;
        return e;
    endfunction
    function automatic exp_t s_mwb();
        exp_t e = '0;
        e.reg_write = 1; e.mem_to_reg = 1; e.instr_done = 1;
        return e;
    endfunction
    function automatic exp_t s_mwrite(bit w);
        exp_t e = '0;
        e.iord = 1; e.mem_write = 1; e.instr_done = !w;
        return e;
    endfunction
    function automatic exp_t s_rexec(logic [1:0] op);
        exp_t e = '0;
        e.alu_src_a = 1; e.alu_src_b = 1; e.alu_op = op;
        return e;
    endfunction
    function automatic exp_t s_rwb();
        exp_t e = '0;
        e.reg_write = 1; e.reg_dst = 1; e.instr_done = 1;
        return e;
    endfunction
    function automatic exp_t s_iexec();
        exp_t e = '0;
        e.alu_src_a = 1; e.alu_src_b = 2; e.alu_op = 2;
        return e;
    endfunction
    function automatic exp_t s_iwb();
        exp_t e = '0;
        e.reg_write = 1; e.instr_done = 1;
        return e;
    endfunction
    function automatic exp_t s_branch(bit z);
        exp_t e = '0;
        e.alu_src_a = 1; e.alu_src_b = 1; e.alu_op = 1;
        e.pc_src = 1; e.pc_en = !z; e.instr_done = 1;
        return e;
    endfunction
    function automatic exp_t s_jump(logic [1:0] src);
        exp_t e = '0;
        e.pc_src = src; e.pc_en = 1; e.instr_done = 1;
        return e;
    endfunction
    function automatic exp_t s_jal();
        exp_t e = s_jump(3);
        e.reg_write = 1; e.reg_dst = 2; e.mem_to_reg = 2;
        return e;
    endfunction

    // queue one cycle's expectation, then advance to just after the edge
    task automatic cyc(string nm, exp_t e);
        e.illegal = ill;
        qe.push_back(e);
        qn.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic fd(logic [5:0] op, logic [5:0] fn, string nm);
        opcode = op; funct = fn; mem_wait = 0;
        cyc({nm, "/FETCH"}, s_fetch(0));
        cyc({nm, "/DECODE"}, s_decode());
    endtask

    initial begin
        rst_n = 0; opcode = 0; funct = 0; alu_zero = 0; mem_wait = 0;
        @(posedge clk); #1;
        cyc("reset", s_zero());
        rst_n = 1;
        cyc("idle", s_zero());

        fd(6'h23, 6'h00, "LW");
        cyc("LW/MADDR", s_maddr());
        cyc("LW/MREAD", s_mread());
        cyc("LW/MWB", s_mwb());

        fd(6'h23, 6'h00, "LWw");
        cyc("LWw/MADDR", s_maddr());
        mem_wait = 1;
        cyc("LWw/MREAD_w1", s_mread());
        cyc("LWw/MREAD_w2", s_mread());
        mem_wait = 0;
        cyc("LWw/MREAD", s_mread());
        cyc("LWw/MWB", s_mwb());

        opcode = 6'h2B; mem_wait = 1;
        cyc("SWw/FETCH_w", s_fetch(1));
        fd(6'h2B, 6'h00, "SWw");
        cyc("SWw/MADDR", s_maddr());
        mem_wait = 1;
        cyc("SWw/MWRITE_w", s_mwrite(1));
        mem_wait = 0;
        cyc("SWw/MWRITE", s_mwrite(0));

        fd(6'h00, 6'h20, "ADD");
        cyc("ADD/EXEC", s_rexec(0));
        cyc("ADD/WB", s_rwb());
        fd(6'h00, 6'h22, "SUB");
        cyc("SUB/EXEC", s_rexec(1));
        cyc("SUB/WB", s_rwb());
        fd(6'h00, 6'h2A, "SLT");
        cyc("SLT/EXEC", s_rexec(3));
        cyc("SLT/WB", s_rwb());

        fd(6'h0E, 6'h00, "XORI");
        mem_wait = 1;
        cyc("XORI/EXEC", s_iexec());
        mem_wait = 0;
        cyc("XORI/WB", s_iwb());

        fd(6'h05, 6'h00, "BNE0");
        alu_zero = 0;
        cyc("BNE0/BRANCH", s_branch(0));
        fd(6'h05, 6'h00, "BNE1");
        alu_zero = 1;
        cyc("BNE1/BRANCH", s_branch(1));
        alu_zero = 0;

        fd(6'h02, 6'h00, "J");
        mem_wait = 1;
        cyc("J/JUMP", s_jump(3));
        mem_wait = 0;
        fd(6'h03, 6'h00, "JAL");
        cyc("JAL/JAL", s_jal());
        fd(6'h00, 6'h08, "JR");
        cyc("JR/JR", s_jump(2));

        fd(6'h3F, 6'h00, "ILL");
        ill = 1'b1;
        fd(6'h2B, 6'h00, "SWi");
        cyc("SWi/MADDR", s_maddr());
        cyc("SWi/MWRITE", s_mwrite(0));
        fd(6'h00, 6'h3F, "ILLF");

        fd(6'h00, 6'h20, "RST");
        #2 rst_n = 0; ill = 1'b0;
        cyc("RST/abort", s_zero());
        cyc("RST/held", s_zero());
        rst_n = 1;
        cyc("RST/idle", s_zero());
        opcode = 6'h00; funct = 6'h20;
        cyc("RST/FETCH", s_fetch(0));
        cyc("RST/DECODE", s_decode());

        @(negedge clk);
        n_run++;
        if (qe.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending want 0", qe.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
